bsg_one_hot_phase_sequencer: RTL and testbench

//  Command-driven controller placed directly upstream of a one-hot clear/up counter (max_val_p+1 states).

---
 rtl/bsg_one_hot_phase_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_bsg_one_hot_phase_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_one_hot_phase_sequencer.sv
// -----------------------------------------------------------------------------
// bsg_one_hot_phase_sequencer
//
// Command-driven controller that sits directly upstream of a one-hot
// clear/up counter with max_val_p+1 states. It accepts valid/ready
// commands. A command is either a clear or a run of N up pulses. The
// controller drives the counter's clear/up inputs as registered one-cycle
// pulses. When a command completes, it reads the counter's one-hot value
// back and reports it as a binary phase.
//
// Alongside that it keeps a saturating count of counter wrap-arounds. It
// also raises a sticky error if the fed-back count is ever not one-hot
// when it is sampled.
//
// Ports
//   clk_i        : clock, all logic on the rising edge
//   reset_n_i    : synchronous, active-low reset
//   v_i          : command valid
//   ready_o      : command accepted on a cycle with v_i & ready_o
//   cmd_clear_i  : 1 = clear command, 0 = step command
//   cmd_steps_i  : number of up pulses for a step command (clamped to max_val_p)
//   up_o         : to counter up input, one-cycle pulses
//   clear_o      : to counter clear input, one-cycle pulse
//   count_i      : one-hot count fed back from the counter
//   done_o       : one-cycle pulse, command complete
//   phase_o      : binary index of the count_i bit captured at settle
//   wraps_o      : saturating count of counter wrap-arounds
//   err_o        : sticky, count_i was not one-hot at settle
// -----------------------------------------------------------------------------
module bsg_one_hot_phase_sequencer #(
  parameter  int max_val_p    = 64,
  parameter  int wrap_width_p = 8,
  localparam int lg_lp        = $clog2(max_val_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,

  input  logic                    v_i,
  output logic                    ready_o,
  input  logic                    cmd_clear_i,
  input  logic [lg_lp-1:0]        cmd_steps_i,

  output logic                    up_o,
  output logic                    clear_o,
  input  logic [max_val_p:0]      count_i,

  output logic                    done_o,
  output logic [lg_lp-1:0]        phase_o,
  output logic [wrap_width_p-1:0] wraps_o,
  output logic                    err_o
);

  typedef enum logic [2:0] {
    IDLE_S,
    STEP_S,
    CLR_S,
    SETTLE_S,
    DONE_S
  } state_e;

  localparam logic [lg_lp-1:0]     max_steps_lp = lg_lp'(max_val_p);
  localparam logic [lg_lp-1:0]     one_step_lp  = lg_lp'(1);
  localparam logic [max_val_p:0]   count_one_lp = (max_val_p + 1)'(1);

  state_e                    state_q, state_d;
  logic [lg_lp-1:0]          remaining_q, remaining_d;
  logic                      up_q, clear_q, done_q;
  logic [lg_lp-1:0]          phase_q, phase_d;
  logic [wrap_width_p-1:0]   wraps_q, wraps_d;
  logic                      err_q, err_d;

  logic                      accept;
  logic [lg_lp-1:0]          steps_clamped;

  // ---------------------------------------------------------------------------
  // Command handshake
  // ---------------------------------------------------------------------------
  // ready_o is gated with reset so that no command can be taken on the
  // same edge that resets the controller.
  assign ready_o = (state_q == IDLE_S) && reset_n_i;
  assign accept  = v_i && ready_o;

  assign steps_clamped = (cmd_steps_i > max_steps_lp) ? max_steps_lp : cmd_steps_i;

  // ---------------------------------------------------------------------------
  // Count decode: one-hot check and binary index of the set bit
  // ---------------------------------------------------------------------------
  // x & (x-1) clears the lowest set bit. A nonzero x is one-hot exactly
  // when that result is zero.
  logic [max_val_p:0] count_minus_one;
  logic               count_one_hot;

  assign count_minus_one = count_i - count_one_lp;
  assign count_one_hot   = (count_i != '0) && ((count_i & count_minus_one) == '0);

  // Each set bit contributes its own index. The results are ORed together,
  // which gives the true index whenever the input is one-hot. The result is
  // only used in that case.
  logic [lg_lp-1:0] index_terms [max_val_p+1];
  logic [lg_lp-1:0] count_index;

  for (genvar gi = 0; gi <= max_val_p; gi++) begin : g_index_terms
    assign index_terms[gi] = count_i[gi] ? lg_lp'(gi) : '0;
  end

  always_comb begin
    count_index = '0;
    for (int i = 0; i <= max_val_p; i++) begin
      count_index = count_index | index_terms[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;

    unique case (state_q)
      IDLE_S: begin
        if (accept) begin
          remaining_d = steps_clamped;
          if (cmd_clear_i) begin
            state_d = CLR_S;
          end else if (steps_clamped == '0) begin
            // A zero-step command goes straight to sampling the count.
            state_d = SETTLE_S;
          end else begin
            state_d = STEP_S;
          end
        end
      end

      STEP_S: begin
        // Each cycle spent here issues one up pulse. Leave after the last one.
        if (remaining_q <= one_step_lp) begin
          state_d = SETTLE_S;
        end else begin
          remaining_d = remaining_q - one_step_lp;
        end
      end

      CLR_S: begin
        state_d = SETTLE_S;
      end

      // The counter has absorbed the final pulse by now, so count_i is
      // sampled during this state.
      SETTLE_S: begin
        state_d = DONE_S;
      end

      DONE_S: begin
        state_d = IDLE_S;
      end

      default: begin
        state_d = IDLE_S;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Phase capture, error flag and wrap counter
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_d = phase_q;
    err_d   = err_q;
    wraps_d = wraps_q;

    if (state_q == SETTLE_S) begin
      if (count_one_hot) begin
        phase_d = count_index;
      end else begin
        phase_d = '0;
        err_d   = 1'b1;
      end
    end

    // An up pulse issued while the counter sits at its top state rolls it
    // over to state 0. The count holds at all-ones once it saturates.
    if (up_q && count_i[max_val_p] && !(&wraps_q)) begin
      wraps_d = wraps_q + wrap_width_p'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // The pulse outputs are decoded from the next state and registered. This
  // way they line up exactly with the state they belong to and never glitch.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE_S;
      remaining_q <= '0;
      up_q        <= 1'b0;
      clear_q     <= 1'b0;
      done_q      <= 1'b0;
      phase_q     <= '0;
      wraps_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      up_q        <= (state_d == STEP_S);
      clear_q     <= (state_d == CLR_S);
      done_q      <= (state_d == DONE_S);
      phase_q     <= phase_d;
      wraps_q     <= wraps_d;
      err_q       <= err_d;
    end
  end

  assign up_o    = up_q;
  assign clear_o = clear_q;
  assign done_o  = done_q;
  assign phase_o = phase_q;
  assign wraps_o = wraps_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_bsg_one_hot_phase_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for bsg_one_hot_phase_sequencer.
//
// A one-hot counter model sits downstream of the DUT, as it would in the
// real system. A command-level model predicts, for every cycle, which
// pulses must appear, when ready/done must be seen, and what phase, wrap
// count and error flag must be reported. These predictions come from each
// accepted command's start edge and step count. A per-cycle compare
// process checks the DUT against the model. Directed tests add literal
// expectations on top.
// -----------------------------------------------------------------------------
module tb_bsg_one_hot_phase_sequencer;

  localparam int MAXV = 64;
  localparam int WW   = 8;
  localparam int LG   = 7;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic          v_i;
  logic          ready_o;
  logic          cmd_clear_i;
  logic [LG-1:0] cmd_steps_i;
  logic          up_o;
  logic          clear_o;
  logic [MAXV:0] count_i;
  logic          done_o;
  logic [LG-1:0] phase_o;
  logic [WW-1:0] wraps_o;
  logic          err_o;

  logic [MAXV:0] cnt_q;
  logic [MAXV:0] force_val;
  logic          force_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_one_hot_phase_sequencer #(
    .max_val_p   (MAXV),
    .wrap_width_p(WW)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n_i),
    .v_i        (v_i),
    .ready_o    (ready_o),
    .cmd_clear_i(cmd_clear_i),
    .cmd_steps_i(cmd_steps_i),
    .up_o       (up_o),
    .clear_o    (clear_o),
    .count_i    (count_i),
    .done_o     (done_o),
    .phase_o    (phase_o),
    .wraps_o    (wraps_o),
    .err_o      (err_o)
  );

  // Downstream one-hot counter: reset/clear to state 0, up rotates left.
  always @(posedge clk) begin
    if (reset_n_i !== 1'b1)  cnt_q <= (MAXV + 1)'(1);
    else if (clear_o)        cnt_q <= (MAXV + 1)'(1);
    else if (up_o)           cnt_q <= {cnt_q[MAXV-1:0], cnt_q[MAXV]};
  end

  assign count_i = force_en ? force_val : cnt_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Command-level model
  // ---------------------------------------------------------------------------
  // cyc numbers the clock periods. An accept on the edge that ends cycle t
  // schedules its pulses in cycles t+1 onwards.
  int cyc      = 0;
  int up_lo    = 1;
  int up_hi    = 0;
  int clr_c    = -1;
  int settle_c = -1;
  int done_c   = -1;
  int free_c   = 0;
  int m_phase  = 0;
  int m_wraps  = 0;
  bit m_err    = 1'b0;
  bit started  = 1'b0;

  function automatic int idx_of(input logic [MAXV:0] v);
    for (int i = 0; i <= MAXV; i++) begin
      if (v[i] === 1'b1) return i;
    end
    return 0;
  endfunction

  task automatic model_step();
    int e;
    int n;
    e = cyc;
    if (reset_n_i !== 1'b1) begin
      up_lo = 1; up_hi = 0; clr_c = -1; settle_c = -1; done_c = -1;
      free_c = 0; m_phase = 0; m_wraps = 0; m_err = 1'b0;
      started = 1'b1;
    end else if (started) begin
      if (e >= up_lo && e <= up_hi && count_i[MAXV] === 1'b1 && m_wraps < 255)
        m_wraps++;
      if (e == settle_c) begin
        if ($countones(count_i) == 1) m_phase = idx_of(count_i);
        else begin
          m_phase = 0;
          m_err   = 1'b1;
        end
      end
      if (v_i === 1'b1 && e >= free_c) begin
        n = (int'(cmd_steps_i) > MAXV) ? MAXV : int'(cmd_steps_i);
        if (cmd_clear_i === 1'b1) begin
          clr_c = e + 1; settle_c = e + 2; done_c = e + 3; free_c = e + 4;
        end else begin
          up_lo = e + 1; up_hi = e + n;
          settle_c = e + n + 1; done_c = e + n + 2; free_c = e + n + 3;
        end
      end
    end
    cyc = e + 1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle compare, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("ready", 32'(ready_o), 32'(reset_n_i === 1'b1 && cyc >= free_c));
        chk("up",    32'(up_o),    32'(cyc >= up_lo && cyc <= up_hi));
        chk("clear", 32'(clear_o), 32'(cyc == clr_c));
        chk("done",  32'(done_o),  32'(cyc == done_c));
        chk("phase", 32'(phase_o), 32'(m_phase));
        chk("wraps", 32'(wraps_o), 32'(m_wraps));
        chk("err",   32'(err_o),   32'(m_err));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Called 2 time units after a rising edge of an idle cycle. Returns at the
  // same offset in the idle cycle after DONE. lat is measured in cycles after
  // the accept edge.
  task automatic run_cmd(input logic clr, input logic [LG-1:0] steps,
                         output int lat, output int ups, output int clrs,
                         output int upf, output int upl);
    int acc;
    int got;
    cmd_clear_i = clr;
    cmd_steps_i = steps;
    v_i = 1'b1;
    acc = 0;
    for (int w = 0; w < 20 && acc == 0; w++) begin
      @(negedge clk);
      if (ready_o === 1'b1) acc = 1;
      @(posedge clk); #2;
    end
    v_i = 1'b0;
    chk("accept", 32'(acc), 32'd1);
    lat = 0; ups = 0; clrs = 0; upf = -1; upl = -1; got = 0;
    for (int k = 1; k <= 200 && got == 0; k++) begin
      @(negedge clk);
      if (up_o === 1'b1) begin
        ups++;
        if (upf < 0) upf = k;
        upl = k;
      end
      if (clear_o === 1'b1) clrs++;
      if (done_o === 1'b1) begin
        got = 1;
        lat = k;
      end
      @(posedge clk); #2;
    end
    chk("done_seen", 32'(got), 32'd1);
    $display("cmd clear=%0d steps=%0d lat=%0d ups=%0d clears=%0d phase=%0d wraps=%0d err=%0d",
             clr, steps, lat, ups, clrs, phase_o, wraps_o, err_o);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int lat, ups, clrs, upf, upl;
    int accepts, dones, first_done, rdy;

    reset_n_i = 1'b0; v_i = 1'b0; cmd_clear_i = 1'b0; cmd_steps_i = '0;
    force_en = 1'b0; force_val = '0;

    // 1: reset, then clear
    repeat (2) @(posedge clk);
    #2 reset_n_i = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_up",    32'(up_o),    32'd0);
    chk("rst_clear", 32'(clear_o), 32'd0);
    chk("rst_done",  32'(done_o),  32'd0);
    chk("rst_phase", 32'(phase_o), 32'd0);
    chk("rst_wraps", 32'(wraps_o), 32'd0);
    chk("rst_err",   32'(err_o),   32'd0);
    @(posedge clk); #2;

    run_cmd(1'b1, 7'd0, lat, ups, clrs, upf, upl);
    chk("t1_lat", 32'(lat), 32'd3);
    chk("t1_clears", 32'(clrs), 32'd1);
    chk("t1_ups", 32'(ups), 32'd0);
    chk("t1_phase", 32'(phase_o), 32'd0);

    // 2: five steps from phase 0
    run_cmd(1'b0, 7'd5, lat, ups, clrs, upf, upl);
    chk("t2_lat", 32'(lat), 32'd7);
    chk("t2_ups", 32'(ups), 32'd5);
    chk("t2_upfirst", 32'(upf), 32'd1);
    chk("t2_uplast", 32'(upl), 32'd5);
    chk("t2_clears", 32'(clrs), 32'd0);
    chk("t2_phase", 32'(phase_o), 32'd5);
    chk("t2_wraps", 32'(wraps_o), 32'd0);

    // 3: clear, step 64 to the top state, step 3 wraps once
    run_cmd(1'b1, 7'd0, lat, ups, clrs, upf, upl);
    run_cmd(1'b0, 7'd64, lat, ups, clrs, upf, upl);
    chk("t3_phase64", 32'(phase_o), 32'd64);
    chk("t3_wraps0", 32'(wraps_o), 32'd0);
    run_cmd(1'b0, 7'd3, lat, ups, clrs, upf, upl);
    chk("t3_lat", 32'(lat), 32'd5);
    chk("t3_phase", 32'(phase_o), 32'd2);
    chk("t3_wraps", 32'(wraps_o), 32'd1);

    // Out-of-range step count is clamped to 64: phase 2 -> 1, one more wrap
    run_cmd(1'b0, 7'd100, lat, ups, clrs, upf, upl);
    chk("clamp_ups", 32'(ups), 32'd64);
    chk("clamp_lat", 32'(lat), 32'd66);
    chk("clamp_phase", 32'(phase_o), 32'd1);
    chk("clamp_wraps", 32'(wraps_o), 32'd2);

    // 4: step 0 with v_i held high for 12 cycles -> an accept in every idle cycle
    cmd_clear_i = 1'b0; cmd_steps_i = '0; v_i = 1'b1;
    accepts = 0; dones = 0; first_done = -1; ups = 0; clrs = 0; rdy = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ready_o === 1'b1) rdy++;
      if (ready_o === 1'b1 && v_i === 1'b1) accepts++;
      if (up_o === 1'b1) ups++;
      if (clear_o === 1'b1) clrs++;
      if (done_o === 1'b1) begin
        dones++;
        if (first_done < 0) first_done = k;
      end
      @(posedge clk); #2;
    end
    v_i = 1'b0;
    $display("cmd hold-valid steps=0 accepts=%0d dones=%0d phase=%0d", accepts, dones, phase_o);
    chk("t4_accepts", 32'(accepts), 32'd4);
    chk("t4_ready_cycles", 32'(rdy), 32'd4);
    chk("t4_dones", 32'(dones), 32'd4);
    chk("t4_first_done", 32'(first_done), 32'd2);
    chk("t4_ups", 32'(ups), 32'd0);
    chk("t4_clears", 32'(clrs), 32'd0);
    chk("t4_phase", 32'(phase_o), 32'd1);

    // 5: non-one-hot counts at settle set the sticky error
    force_en = 1'b1; force_val = '0;
    run_cmd(1'b0, 7'd0, lat, ups, clrs, upf, upl);
    chk("t5_err_zero", 32'(err_o), 32'd1);
    chk("t5_phase_zero", 32'(phase_o), 32'd0);
    force_val = (MAXV + 1)'(3);
    run_cmd(1'b0, 7'd0, lat, ups, clrs, upf, upl);
    chk("t5_err_two", 32'(err_o), 32'd1);
    chk("t5_phase_two", 32'(phase_o), 32'd0);
    force_en = 1'b0;
    run_cmd(1'b0, 7'd2, lat, ups, clrs, upf, upl);
    chk("t5_err_sticky", 32'(err_o), 32'd1);
    chk("t5_phase_good", 32'(phase_o), 32'd3);

    // 6: reset in the middle of a 10-step command
    cmd_clear_i = 1'b0; cmd_steps_i = 7'd10; v_i = 1'b1;
    @(negedge clk);
    chk("t6_ready", 32'(ready_o), 32'd1);
    @(posedge clk); #2;
    v_i = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset_n_i = 1'b0;
    @(negedge clk);
    chk("t6_up_before", 32'(up_o), 32'd1);
    @(posedge clk); #2;
    reset_n_i = 1'b1;
    @(negedge clk);
    chk("t6_up_after", 32'(up_o), 32'd0);
    chk("t6_wraps", 32'(wraps_o), 32'd0);
    chk("t6_err", 32'(err_o), 32'd0);
    dones = 0; ups = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #2;
      @(negedge clk);
      if (done_o === 1'b1) dones++;
      if (up_o === 1'b1) ups++;
    end
    $display("cmd reset-abort steps=10 dones=%0d ups=%0d wraps=%0d", dones, ups, wraps_o);
    chk("t6_no_done", 32'(dones), 32'd0);
    chk("t6_no_up", 32'(ups), 32'd0);
    @(posedge clk); #2;

    // 310 commands of 64 steps are more than 300 full wraps -> saturation
    for (int c = 0; c < 310; c++) begin
      run_cmd(1'b0, 7'd64, lat, ups, clrs, upf, upl);
    end
    chk("t6_wraps_sat", 32'(wraps_o), 32'd255);

    repeat (3) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
